lab7_fetch: RTL and testbench

- Instruction fetch stage; sits directly upstream of the decode stage and supplies its 32-bit `komut` instruction word.
- Holds the program counter and a word-addressed instruction memory, loadable through a write port.
- Fetched words are buffered in a small FIFO and handed to decode over a valid/ready handshake.
- Accepts PC redirects (branch taken) from execute and flushes stale words.

---
 rtl/lab7_pkg.sv | 27 ++
 rtl/lab7_fetch_fifo.sv | 61 ++++++
 rtl/lab7_fetch.sv | 125 ++++++++++++
 tb/tb_lab7_fetch.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lab7_pkg.sv
// Shared types and constants for the lab7 fetch stage: state encoding,
// buffered-entry layout and the opcode constants decode keys on.
package lab7_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R = 7'b0000001;
  localparam logic [6:0] OP_I = 7'b0000011;
  localparam logic [6:0] OP_U = 7'b0000111;
  localparam logic [6:0] OP_B = 7'b0001111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ERR   = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/lab7_fetch_fifo.sv
// Small synchronous FIFO of {pc, word} entries between fetch and decode.
// Clear wins over push/pop; push while full is accepted only with a same-edge pop.
module lab7_fetch_fifo
  import lab7_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  fetch_entry_t            push_entry,
  input  logic                    pop,
  input  logic                    clear,
  output fetch_entry_t            head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage arrays are not reset; validity comes solely from count.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_entry;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/lab7_fetch.sv
// Instruction fetch stage: PC, loadable word-addressed instruction memory with
// 1-cycle synchronous read, output FIFO to decode, redirect flush and fault trap.
module lab7_fetch
  import lab7_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  input  logic                          komut_ready,
  output logic [31:0]                   komut,
  output logic [31:0]                   komut_pc,
  output logic                          komut_valid,
  output logic                          hata
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rd_pc;
  logic [XLEN-1:0] rd_word;
  logic            inflight;
  logic [XLEN-1:0] imem [IMEM_DEPTH];

  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;

  logic            redir;
  logic            pop;
  logic            push;
  logic [CW:0]     occ;
  logic [CW:0]     limit;
  logic            room;
  logic            attempt;
  logic            fault;
  logic            issue;

  // Redirect flushes everything in the pipe and outranks issue, push and pop.
  assign redir = redirect_valid && (state != ERR);
  assign pop   = !fifo_empty && komut_ready && !redir;
  assign push  = inflight && !redir;

  // A same-edge pop frees a slot, which keeps 1 word/cycle with a 2-entry buffer.
  assign occ     = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign limit   = (CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop};
  assign room    = (occ < limit);
  assign attempt = (state == FETCH) && run && !redir && room;
  assign fault   = attempt && ((pc[1:0] != 2'b00) || (pc[XLEN-1:AW+2] != '0));
  assign issue   = attempt && !fault;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default assignment first so no path through always_comb infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = FETCH;
      FETCH: begin
        if (fault)     state_nxt = ERR;
        else if (!run) state_nxt = IDLE;
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    komut       = head.word;
    komut_pc    = head.pc;
    komut_valid = !fifo_empty;
    hata        = (state == ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      rd_pc    <= '0;
      inflight <= 1'b0;
    end else begin
      if (redir)      pc <= redirect_pc;
      else if (issue) pc <= next_pc(pc);
      if (issue) rd_pc <= pc;
      inflight <= issue;
    end
  end

  // Read and write share one edge, so a same-address collision returns the old word.
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
    if (issue)   rd_word <= imem[pc[AW+1:2]];
  end

  assign push_entry = '{pc: rd_pc, word: rd_word};

  lab7_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .clear      (redir),
    .head       (head),
    .count      (fifo_count),
    .empty      (fifo_empty)
  );

endmodule

// File: tb/tb_lab7_fetch.sv
// Self-checking bench for lab7_fetch: scoreboard of expected {pc, word}
// deliveries plus directed checks on latency, backpressure, redirect, fault, reset.
module tb_lab7_fetch;
  import lab7_pkg::*;

  logic        clk;
  logic        reset;
  logic        run;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        komut_ready;
  logic [31:0] komut;
  logic [31:0] komut_pc;
  logic        komut_valid;
  logic        hata;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]  model_mem [256];
  fetch_entry_t exp_q [$];

  lab7_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .komut_ready    (komut_ready),
    .komut          (komut),
    .komut_pc       (komut_pc),
    .komut_valid    (komut_valid),
    .hata           (hata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic fetch_entry_t entry_at(input logic [31:0] pc);
    logic [7:0] idx;
    idx = pc[9:2];
    return '{pc: pc, word: model_mem[idx]};
  endfunction

  // Transfers happen at the next posedge when valid && ready with no redirect.
  always @(negedge clk) begin
    if (reset && komut_valid && komut_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_delivery", 64'(exp_q.size()), 64'd1);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        check("komut_pc", 64'(komut_pc), 64'(e.pc));
        check("komut", 64'(komut), 64'(e.word));
      end
    end
  end

  task automatic fetch_once(input logic [31:0] pc, input logic wr, input logic [31:0] new_word);
    logic [7:0] idx;
    idx = pc[9:2];
    exp_q.push_back(entry_at(pc));
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    run            = 1'b1;
    komut_ready    = 1'b1;
    tick();
    redirect_valid = 1'b0;
    imem_we        = wr;
    imem_waddr     = idx;
    imem_wdata     = new_word;
    tick();
    imem_we = 1'b0;
    run     = 1'b0;
    if (wr) model_mem[idx] = new_word;
    repeat (4) tick();
    check("once_q_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset          = 1'b0;
    run            = 1'b0;
    imem_we        = 1'b0;
    imem_waddr     = '0;
    imem_wdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    komut_ready    = 1'b0;
    for (int i = 0; i < 256; i++)
      model_mem[i] = (i < 4) ? ((32'd2 << i) - 32'd1) : (32'hC0DE_0000 | 32'(i));

    #12;
    check("rst_valid", 64'(komut_valid), 64'd0);
    check("rst_komut", 64'(komut), 64'd0);
    check("rst_komut_pc", 64'(komut_pc), 64'd0);
    check("rst_hata", 64'(hata), 64'd0);
    check("rst_pc", 64'(dut.pc), 64'd0);
    tick();
    reset = 1'b1;

    for (int i = 0; i < 256; i++) begin
      imem_we    = 1'b1;
      imem_waddr = 8'(i);
      imem_wdata = model_mem[i];
      tick();
    end
    imem_we = 1'b0;

    // Straight-line fetch: latency and 1 word/cycle.
    for (int i = 0; i < 4; i++) exp_q.push_back(entry_at(32'(i * 4)));
    run = 1'b1;
    komut_ready = 1'b1;
    tick();
    check("lat_e0_valid", 64'(komut_valid), 64'd0);
    tick();
    check("lat_e1_valid", 64'(komut_valid), 64'd0);
    tick();
    check("lat_e2_valid", 64'(komut_valid), 64'd1);
    check("lat_e2_pc", 64'(komut_pc), 64'd0);
    tick();
    check("tput_e3_pc", 64'(komut_pc), 64'd4);
    tick();
    check("tput_e4_pc", 64'(komut_pc), 64'd8);
    run = 1'b0;
    repeat (4) tick();
    check("line_q_empty", 64'(exp_q.size()), 64'd0);
    check("stop_pc", 64'(dut.pc), 64'd16);
    check("stop_state", 64'(dut.state), 64'(IDLE));
    check("stop_valid", 64'(komut_valid), 64'd0);

    // Backpressure.
    komut_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    run            = 1'b1;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    check("bp_first_valid", 64'(komut_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_komut", 64'(komut), 64'h1);
      check("bp_hold_pc", 64'(komut_pc), 64'd0);
    end
    check("bp_count", 64'(dut.fifo_count), 64'd2);
    check("bp_pc", 64'(dut.pc), 64'd8);
    for (int i = 0; i < 3; i++) exp_q.push_back(entry_at(32'(i * 4)));
    komut_ready = 1'b1;
    tick();
    run = 1'b0;
    repeat (4) tick();
    check("bp_q_empty", 64'(exp_q.size()), 64'd0);
    check("bp_end_pc", 64'(dut.pc), 64'd12);

    // Redirect with buffered data.
    komut_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    run            = 1'b1;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    check("rd_count", 64'(dut.fifo_count), 64'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    tick();
    redirect_valid = 1'b0;
    komut_ready    = 1'b1;
    check("rd_valid_low", 64'(komut_valid), 64'd0);
    exp_q.push_back(entry_at(32'h20));
    tick();
    run = 1'b0;
    check("rd_valid_low2", 64'(komut_valid), 64'd0);
    tick();
    check("rd_valid_back", 64'(komut_valid), 64'd1);
    repeat (3) tick();
    check("rd_q_empty", 64'(exp_q.size()), 64'd0);
    check("rd_pc", 64'(dut.pc), 64'h24);

    // Write collision returns the old word, then the new word is visible.
    fetch_once(32'h40, 1'b1, 32'hDEAD_BEEF);
    fetch_once(32'h40, 1'b0, 32'h0);

    // Fault.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h402;
    run            = 1'b1;
    komut_ready    = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("flt_pre_hata", 64'(hata), 64'd0);
    tick();
    check("flt_hata", 64'(hata), 64'd1);
    check("flt_state", 64'(dut.state), 64'(ERR));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    check("flt_redir_ignored", 64'(dut.pc), 64'h402);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flt_no_valid", 64'(komut_valid), 64'd0);
      check("flt_sticky", 64'(hata), 64'd1);
    end
    #2 reset = 1'b0;
    #1;
    check("flt_clear_hata", 64'(hata), 64'd0);
    run = 1'b0;
    tick();
    reset = 1'b1;

    // Async reset mid-burst.
    exp_q.push_back(entry_at(32'h0));
    exp_q.push_back(entry_at(32'h4));
    run = 1'b1;
    komut_ready = 1'b1;
    repeat (5) tick();
    check("burst_valid", 64'(komut_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 64'(komut_valid), 64'd0);
    check("arst_komut", 64'(komut), 64'd0);
    check("arst_hata", 64'(hata), 64'd0);
    check("arst_pc", 64'(dut.pc), 64'd0);
    check("arst_q_empty", 64'(exp_q.size()), 64'd0);
    run = 1'b0;
    tick();
    reset = 1'b1;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
